// File: rtl/decoder38_rr_sched.sv
// Round-robin scheduler that owns the select and enables of a shared decoder38.
// One requester holds the decoder at a time, bounded by a hold timeout, with a fixed dead gap between grants.
module decoder38_rr_sched #(
    parameter int HOLD_MAX   = 15,
    parameter int CNT_W      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic       sta,
    output logic       stb,
    output logic       stc,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [3:0]       GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       ptr;
    logic [2:0]       ptr_nxt;
    logic [2:0]       sel_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_nxt;
    logic [3:0]       gap_cnt;
    logic [3:0]       gap_nxt;
    logic             timeout_nxt;
    logic             start;
    logic [2:0]       winner;

    // Search begins just after the last served requester, so it is always last in line.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = p + 3'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign start  = en && (req != 8'd0);
    assign winner = pick(req, ptr);

    always_comb begin
        // NOTE: every next-value gets a default before the case so no path leaves one unassigned, which would infer a latch.
        state_nxt   = state;
        ptr_nxt     = ptr;
        sel_nxt     = sel;
        hold_nxt    = hold_cnt;
        gap_nxt     = gap_cnt;
        timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    sel_nxt   = winner;
                    hold_nxt  = '0;
                    state_nxt = GRANT;
                end
            end

            GRANT: begin
                // A release on the same edge as the hold limit wins and suppresses the pulse.
                if (!req[sel]) begin
                    ptr_nxt   = sel;
                    gap_nxt   = '0;
                    state_nxt = GAP;
                end else if (hold_cnt == HOLD_LAST) begin
                    timeout_nxt = 1'b1;
                    ptr_nxt     = sel;
                    gap_nxt     = '0;
                    state_nxt   = GAP;
                end else begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
            end

            GAP: begin
                gap_nxt = gap_cnt + 4'd1;
                if (gap_cnt == GAP_LAST) begin
                    if (start) begin
                        sel_nxt   = winner;
                        hold_nxt  = '0;
                        state_nxt = GRANT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Decoder controls are registered from the next state, so sel and the enables move on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            ptr         <= 3'd7;
            sel         <= 3'd0;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            sta         <= 1'b0;
            stb         <= 1'b1;
            stc         <= 1'b1;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            sel         <= sel_nxt;
            hold_cnt    <= hold_nxt;
            gap_cnt     <= gap_nxt;
            sta         <= (state_nxt == GRANT);
            stb         <= (state_nxt != GRANT);
            stc         <= (state_nxt != GRANT);
            grant_valid <= (state_nxt == GRANT);
            timeout     <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_decoder38_rr_sched.sv
// Scoreboard bench: a grant-level reference model queues expected outputs per cycle, a monitor pops and compares.
module tb_decoder38_rr_sched;

    localparam int HOLD = 4;
    localparam int GAPC = 1;

    typedef struct packed {
        logic [2:0] sel;
        logic       sta;
        logic       stb;
        logic       stc;
        logic       gv;
        logic       to;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [2:0] sel;
    logic       sta;
    logic       stb;
    logic       stc;
    logic       grant_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;
    obs_t exp_q[$];

    // Reference model: who holds the bus, for how many cycles, and how much dead time remains.
    int who  = -1;
    int age  = 0;
    int dead = 0;
    int last = 7;
    int msel = 0;
    bit pulse = 0;

    decoder38_rr_sched #(
        .HOLD_MAX  (HOLD),
        .CNT_W     (4),
        .GAP_CYCLES(GAPC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .sel        (sel),
        .sta        (sta),
        .stb        (stb),
        .stc        (stc),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b required %b", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic r_rst, input logic r_en, input logic [7:0] r_req);
        obs_t e;
        bit   may_start;
        if (r_rst) begin
            who = -1; age = 0; dead = 0; last = 7; msel = 0; pulse = 0;
        end else begin
            pulse     = 0;
            may_start = 0;
            if (who >= 0) begin
                if (!r_req[3'(who)] || age == HOLD) begin
                    pulse = r_req[3'(who)];
                    last  = who;
                    who   = -1;
                    dead  = GAPC;
                end else begin
                    age++;
                end
            end else if (dead > 0) begin
                dead--;
                may_start = (dead == 0);
            end else begin
                may_start = 1;
            end
            if (may_start && r_en && r_req != 8'd0) begin
                for (int i = 1; i <= 8; i++) begin
                    if (r_req[3'((last + i) % 8)]) begin
                        who = (last + i) % 8;
                        break;
                    end
                end
                age  = 1;
                msel = who;
            end
        end
        e.sel = 3'(msel);
        e.sta = (who >= 0);
        e.stb = !(who >= 0);
        e.stc = !(who >= 0);
        e.gv  = (who >= 0);
        e.to  = pulse;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic e, input logic [7:0] q, input int n);
        repeat (n) begin
            @(negedge clk);
            rst = r;
            en  = e;
            req = q;
            model_step(r, e, q);
        end
    endtask

    // Monitor: the DUT presents its registered outputs every cycle; sample them well after the edge.
    initial begin
        obs_t a;
        obs_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {sel, sta, stb, stc, grant_valid, timeout};
                check("outputs", a, e);
            end
        end
    end

    initial begin
        logic [7:0] rq;
        logic       re;
        logic       rr;
        rst = 1'b1;
        en  = 1'b0;
        req = 8'd0;

        drive(1, 0, 8'h00, 3);
        // Single requester, released after 5 cycles.
        drive(0, 1, 8'h04, 5);
        drive(0, 1, 8'h00, 4);
        // All requesting: rotation with timeouts.
        drive(0, 1, 8'hFF, 9 * (HOLD + GAPC) + 2);
        drive(0, 1, 8'h00, 4);
        // Grant 6, release, then 6 and 0 together: 0 first, then 6.
        drive(0, 1, 8'h40, 2);
        drive(0, 1, 8'h00, 3);
        drive(0, 1, 8'h41, 3 * (HOLD + GAPC));
        drive(0, 1, 8'h00, 4);
        // Release coinciding with the hold limit.
        drive(0, 1, 8'h08, HOLD);
        drive(0, 1, 8'h00, 4);
        // en gating, then en dropped mid-grant.
        drive(0, 0, 8'h10, 10);
        drive(0, 1, 8'h10, 1);
        drive(0, 0, 8'h10, 2);
        drive(0, 0, 8'h00, 4);
        // Reset mid-grant with requests still pending.
        drive(0, 1, 8'h20, 2);
        drive(1, 1, 8'h21, 1);
        drive(0, 1, 8'h21, 6);
        drive(0, 1, 8'h00, 4);

        // Randomised traffic.
        rq = 8'd0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
            end
            re = ($urandom_range(0, 9) != 0);
            rr = ($urandom_range(0, 249) == 0);
            drive(rr, re, rq, 1);
        end
        drive(0, 1, 8'h00, 4);

        @(posedge clk);
        #4;
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        if (n_cmp < 12) begin
            n_err++;
            $display("FAIL too_few_compares: got %0d required >= 12", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
